// File: rtl/dmem_trace_model_if.sv
// Data-port bus between the core (master) and the trace memory (slave),
// including the write-trace drain channel.
interface dmem_trace_model_if #(
    parameter int TRACE_DEPTH = 8
);
    localparam int CW = $clog2(TRACE_DEPTH + 1);

    logic [31:0]   m_data_addr;
    logic [31:0]   m_data_wdata;
    logic [3:0]    m_data_byteen;
    logic          m_data_rd;
    logic [31:0]   m_inst_addr;
    logic [31:0]   m_data_rdata;
    logic          rdata_valid;

    // Trace channel: an entry transfers on a clock edge where trace_valid and
    // trace_ready are both high; trace_valid never depends on trace_ready and
    // the head fields stay stable while trace_valid is high and not popped.
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_addr;
    logic [31:0]   trace_data;
    logic [31:0]   trace_pc;
    logic [CW-1:0] trace_count;
    logic          trace_overflow;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_data_rd, m_inst_addr,
        output trace_ready,
        input  m_data_rdata, rdata_valid,
        input  trace_valid, trace_addr, trace_data, trace_pc, trace_count,
        input  trace_overflow
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_data_rd, m_inst_addr,
        input  trace_ready,
        output m_data_rdata, rdata_valid,
        output trace_valid, trace_addr, trace_data, trace_pc, trace_count,
        output trace_overflow
    );
endinterface

// File: rtl/dmem_trace_model.sv
// Word data memory with byte enables, pipelined reads, range checking, a
// power-up clear sweep and a FIFO trace of every accepted write.
module dmem_trace_model #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WORDS       = 4096,
    parameter int          RD_LAT      = 1,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic             busy,
    output logic             oor_err,
    output logic             dbg_state_o,
    dmem_trace_model_if.slave bus
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CW = $clog2(TRACE_DEPTH + 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   sweep_idx_q;
    logic            busy_q;

    logic [31:0]     mem_q [WORDS];

    logic [32:0]     off_ext;
    logic [31:0]     word_off;
    logic            in_range;
    logic [AW-1:0]   widx;
    logic            run;
    logic            rd_req;
    logic            wr_req;
    logic            wr_acc;
    logic [31:0]     rd_word;
    logic [31:0]     merged;

    // Borrow out of the subtraction flags addresses below ADDR_BASE.
    assign off_ext  = {1'b0, bus.m_data_addr} - {1'b0, ADDR_BASE};
    assign word_off = off_ext[31:0] >> 2;
    assign in_range = !off_ext[32] && (word_off < 32'(WORDS));
    assign widx     = word_off[AW-1:0];

    assign run    = (state_q == S_RUN);
    assign rd_req = run && bus.m_data_rd;
    assign wr_req = run && (bus.m_data_byteen != 4'b0000);
    assign wr_acc = wr_req && in_range;

    assign rd_word = in_range ? mem_q[widx] : 32'h0;

    always_comb begin
        merged = rd_word;
        for (int k = 0; k < 4; k++) begin
            if (bus.m_data_byteen[k]) merged[8*k +: 8] = bus.m_data_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CLEAR;
            sweep_idx_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (sweep_idx_q == AW'(WORDS - 1)) begin
                        state_q     <= S_RUN;
                        busy_q      <= 1'b0;
                        sweep_idx_q <= '0;
                    end else begin
                        sweep_idx_q <= sweep_idx_q + AW'(1);
                    end
                end
                S_RUN:   state_q <= S_RUN;
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    // Storage has no reset; the sweep provides the zero contents.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[sweep_idx_q] <= 32'h0;
        end else if (wr_acc) begin
            mem_q[widx] <= merged;
        end
    end

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] pipe_in_v;
    logic [31:0]       dat_q     [RD_LAT];
    logic [31:0]       pipe_in_d [RD_LAT];

    for (genvar k = 0; k < RD_LAT; k++) begin : g_pipe
        if (k == 0) begin : g_head
            assign pipe_in_v[0] = rd_req;
            assign pipe_in_d[0] = rd_word;
        end else begin : g_tail
            assign pipe_in_v[k] = vld_q[k-1];
            assign pipe_in_d[k] = dat_q[k-1];
        end
    end

    // The last stage only loads on a valid beat so read data holds between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) dat_q[k] <= 32'h0;
        end else begin
            vld_q <= pipe_in_v;
            for (int k = 0; k < RD_LAT; k++) begin
                if (k != RD_LAT - 1) begin
                    dat_q[k] <= pipe_in_d[k];
                end else if (pipe_in_v[k]) begin
                    dat_q[k] <= pipe_in_d[k];
                end
            end
        end
    end

    logic oor_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oor_q <= 1'b0;
        end else if ((rd_req || wr_req) && !in_range) begin
            oor_q <= 1'b1;
        end
    end

    logic [31:0]   fa_q [TRACE_DEPTH];
    logic [31:0]   fd_q [TRACE_DEPTH];
    logic [31:0]   fp_q [TRACE_DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          full;
    logic          pop;
    logic          push_ok;

    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign full    = (cnt_q == CW'(TRACE_DEPTH));
    assign pop     = (cnt_q != '0) && bus.trace_ready;
    assign push_ok = wr_acc && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fa_q[wptr_q] <= {bus.m_data_addr[31:2], 2'b00};
            fd_q[wptr_q] <= merged;
            fp_q[wptr_q] <= bus.m_inst_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop)     rptr_q <= rptr_q + PW'(1);
            if (push_ok && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (!push_ok && pop) cnt_q <= cnt_q - CW'(1);
            if (wr_acc && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign busy               = busy_q;
    assign oor_err            = oor_q;
    assign dbg_state_o        = state_q;
    assign bus.m_data_rdata   = dat_q[RD_LAT-1];
    assign bus.rdata_valid    = vld_q[RD_LAT-1];
    assign bus.trace_valid    = (cnt_q != '0);
    assign bus.trace_addr     = fa_q[rptr_q];
    assign bus.trace_data     = fd_q[rptr_q];
    assign bus.trace_pc       = fp_q[rptr_q];
    assign bus.trace_count    = cnt_q;
    assign bus.trace_overflow = ovf_q;
endmodule
